// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/debug sequencer for a single-cycle RISC-V core.
// Owns the core reset and the per-cycle execute enable. It starts,
// stops and single-steps execution, counts executed cycles, and halts
// on ECALL/EBREAK, on a programmable cycle limit, or on host request.
module core_run_ctrl #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             start,
  input  logic             resume,
  input  logic             step,
  input  logic             halt_req,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic [31:0]      instr,
  output logic             core_rstn,
  output logic             core_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       halt_cause,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CRST   = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [1:0]  CAUSE_HOST  = 2'd1;
  localparam logic [1:0]  CAUSE_TRAP  = 2'd2;
  localparam logic [1:0]  CAUSE_LIMIT = 2'd3;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  // Counter preload so that core_rstn stays low for exactly RST_CYCLES cycles.
  localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES - 1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [3:0]       rst_cnt;
  logic [3:0]       rst_cnt_nxt;
  logic [1:0]       cause_nxt;
  logic             clr_run;
  logic             done_nxt;
  logic             trap_hit;
  logic             limit_hit;
  logic             at_limit;
  logic             halt_any;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (&val) return val;
    return val + 1'b1;
  endfunction

  // ECALL or EBREAK in the instruction word currently presented by imem.
  function automatic logic is_trap(input logic [31:0] word);
    return (word == INSTR_ECALL) || (word == INSTR_EBREAK);
  endfunction

  // Halt conditions evaluated against the instruction executing this cycle.
  always_comb begin
    trap_hit  = is_trap(instr);
    // Extra bit so cycle_count+1 cannot wrap into a false match.
    limit_hit = (cycle_limit != '0) &&
                (({1'b0, cycle_count} + 1'b1) == {1'b0, cycle_limit});
    at_limit  = (cycle_limit != '0) && (cycle_count == cycle_limit);
    halt_any  = trap_hit || limit_hit || halt_req;
  end

  // Next-state, reset-counter and halt-cause selection.
  always_comb begin
    nxt_state   = cur_state;
    rst_cnt_nxt = rst_cnt;
    cause_nxt   = halt_cause;
    clr_run     = 1'b0;
    done_nxt    = 1'b0;
    case (cur_state)
      S_IDLE: begin
        if (start) begin
          nxt_state   = S_CRST;
          rst_cnt_nxt = RST_LOAD;
          clr_run     = 1'b1;
        end
      end
      S_CRST: begin
        if (rst_cnt == 4'd0) nxt_state = S_RUN;
        else                 rst_cnt_nxt = rst_cnt - 4'd1;
      end
      S_RUN, S_STEP: begin
        // Priority: trap, then cycle limit, then host request.
        if (trap_hit)       cause_nxt = CAUSE_TRAP;
        else if (limit_hit) cause_nxt = CAUSE_LIMIT;
        else if (halt_req)  cause_nxt = CAUSE_HOST;
        // A single step always ends after one executed cycle.
        if (halt_any || (cur_state == S_STEP)) begin
          nxt_state = S_HALTED;
          done_nxt  = 1'b1;
        end
      end
      S_HALTED: begin
        if (start) begin
          nxt_state   = S_CRST;
          rst_cnt_nxt = RST_LOAD;
          clr_run     = 1'b1;
        end else if (resume && !at_limit) begin
          // Resuming at the limit would halt again immediately; ignore it.
          nxt_state = S_RUN;
        end else if (step) begin
          nxt_state = S_STEP;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // State register and registered Moore outputs decoded from the next state.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cur_state <= S_IDLE;
      rst_cnt   <= 4'd0;
      core_rstn <= 1'b0;
      core_en   <= 1'b0;
      done      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      rst_cnt   <= rst_cnt_nxt;
      core_rstn <= (nxt_state == S_RUN) || (nxt_state == S_STEP) ||
                   (nxt_state == S_HALTED);
      core_en   <= (nxt_state == S_RUN) || (nxt_state == S_STEP);
      done      <= done_nxt;
    end
  end

  // Executed-cycle counter and latched halt cause; both clear on a new start.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cycle_count <= '0;
      halt_cause  <= 2'd0;
    end else if (clr_run) begin
      cycle_count <= '0;
      halt_cause  <= 2'd0;
    end else begin
      if (core_en) cycle_count <= sat_inc(cycle_count);
      halt_cause <= cause_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed testbench for core_run_ctrl. A straight-line imem stand-in
// presents NOPs, optionally an ECALL at a chosen executed-cycle index.
module tb_core_run_ctrl;

  localparam int CNT_W = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic             clock;
  logic             rstn;
  logic             start;
  logic             resume;
  logic             step;
  logic             halt_req;
  logic [CNT_W-1:0] cycle_limit;
  logic [31:0]      instr;
  logic             core_rstn;
  logic             core_en;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       halt_cause;
  logic             done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic        ecall_on = 1'b0;
  logic [31:0] ecall_at = '0;

  core_run_ctrl #(.RST_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .rstn        (rstn),
    .start       (start),
    .resume      (resume),
    .step        (step),
    .halt_req    (halt_req),
    .cycle_limit (cycle_limit),
    .instr       (instr),
    .core_rstn   (core_rstn),
    .core_en     (core_en),
    .state       (state),
    .cycle_count (cycle_count),
    .halt_cause  (halt_cause),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Straight-line program: PC/4 equals the number of executed cycles.
  assign instr = (ecall_on && cycle_count == ecall_at) ? ECALL : NOP;

  // Counts clock cycles during which done is high.
  always @(posedge clock) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    int n;
    int d0;
    rstn = 1'b0; start = 0; resume = 0; step = 0; halt_req = 0;
    cycle_limit = '0;
    tick(); tick();

    // Reset state
    check("rst_state", state, 0);
    check("rst_core_rstn", core_rstn, 0);
    check("rst_core_en", core_en, 0);
    check("rst_count", cycle_count, 0);
    check("rst_cause", halt_cause, 0);
    check("rst_done", done, 0);
    rstn = 1'b1;
    tick();

    // IDLE ignores resume and step
    resume = 1; step = 1; tick(); resume = 0; step = 0;
    check("idle_ignore", state, 0);

    // Limit run: 376 executed cycles
    cycle_limit = 376;
    start = 1; tick(); start = 0;
    check("crst_state", state, 1);
    n = 0;
    while (state == 3'd1 && n < 50) begin
      if (core_rstn !== 1'b0) n = 100;
      n++; tick();
    end
    check("crst_low_cycles", n, 2);
    check("run_state", state, 2);
    check("run_count0", cycle_count, 0);
    n = 0;
    while (core_en === 1'b1 && n < 1000) begin n++; tick(); end
    check("limit_en_cycles", n, 376);
    check("limit_state", state, 4);
    check("limit_cause", halt_cause, 3);
    check("limit_count", cycle_count, 376);
    check("limit_done", done, 1);
    check("limit_core_rstn", core_rstn, 1);
    d0 = done_cnt;
    for (int i = 0; i < 20; i++) tick();
    check("limit_done_once", done_cnt - d0, 1);
    check("limit_count_stable", cycle_count, 376);
    check("limit_en_stable", core_en, 0);

    // Resume at the limit is ignored
    resume = 1; tick(); resume = 0;
    check("resume_at_limit", state, 4);

    // ECALL at PC 0x20 (9th instruction), no limit
    cycle_limit = 0; ecall_on = 1; ecall_at = 8;
    start = 1; tick(); start = 0;
    n = 0;
    while (state != 3'd4 && n < 200) begin n++; tick(); end
    check("ecall_state", state, 4);
    check("ecall_cause", halt_cause, 2);
    check("ecall_count", cycle_count, 9);
    check("ecall_done", done, 1);

    // ECALL coinciding with the limit: trap wins
    cycle_limit = 5; ecall_at = 4;
    start = 1; tick(); start = 0;
    n = 0;
    while (state != 3'd4 && n < 200) begin n++; tick(); end
    check("prio_cause", halt_cause, 2);
    check("prio_count", cycle_count, 5);
    ecall_on = 0;

    // Host halt at cycle 50, then three steps, then resume
    cycle_limit = 0;
    start = 1; tick(); start = 0;
    n = 0;
    while (cycle_count != 50 && n < 200) begin n++; tick(); end
    check("reach_50", cycle_count, 50);
    step = 1; resume = 1; tick(); step = 0; resume = 0;
    check("run_ignores_inputs", state, 2);
    halt_req = 1; tick(); halt_req = 0;
    check("host_state", state, 4);
    check("host_count", cycle_count, 52);
    check("host_cause", halt_cause, 1);
    check("host_done", done, 1);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      step = 1; tick(); step = 0;
      check("step_state", state, 3);
      check("step_en", core_en, 1);
      tick();
      check("step_halted", state, 4);
      check("step_done", done, 1);
    end
    tick();
    // Pending host-halt done plus one per step
    check("step_done_cnt", done_cnt - d0, 4);
    check("step_count", cycle_count, 55);
    check("step_cause_kept", halt_cause, 1);
    resume = 1; tick(); resume = 0;
    check("resume_state", state, 2);
    check("resume_en", core_en, 1);

    // Asynchronous reset mid-run: no done pulse
    d0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_core_rstn", core_rstn, 0);
    check("arst_core_en", core_en, 0);
    check("arst_count", cycle_count, 0);
    check("arst_cause", halt_cause, 0);
    check("arst_done", done, 0);
    tick(); tick(); tick();
    rstn = 1'b1;
    tick();
    check("arst_no_done", done_cnt - d0, 0);
    cycle_limit = 10;
    start = 1; tick(); start = 0;
    n = 0;
    while (state != 3'd2 && n < 20) begin n++; tick(); end
    check("rerun_state", state, 2);
    check("rerun_count0", cycle_count, 0);
    n = 0;
    while (state != 3'd4 && n < 100) begin n++; tick(); end
    check("rerun_limit_count", cycle_count, 10);

    // start and resume together in HALTED: start wins
    start = 1; resume = 1; tick(); start = 0; resume = 0;
    check("sr_state", state, 1);
    check("sr_count", cycle_count, 0);
    check("sr_cause", halt_cause, 0);
    check("sr_core_rstn", core_rstn, 0);
    tick();
    check("sr_core_rstn2", core_rstn, 0);
    tick();
    check("sr_run", state, 2);
    check("sr_core_rstn3", core_rstn, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: observed running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/debug sequencer wrapped around the single-cycle RISC_V core.
- Owns the core's reset and a per-cycle execute enable. Starts, stops and single-steps program execution.
- Counts executed cycles and halts on ECALL/EBREAK, on a programmable cycle limit, or on host request.
- Replaces hand-written bench reset/delay sequences; RISC_V is stalled via core_en while its state is inspected.

Parameters:
- RST_CYCLES, 2, number of cycles core_rstn is held low after a start; legal range 1..15.
- CNT_W, 32, width of cycle_count and cycle_limit.

Ports:
- clock  in  1  system clock, rising-edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  pulse: reset the core, then run from PC 0.
- resume  in  1  pulse: continue from HALTED without resetting the core.
- step  in  1  pulse: execute exactly one instruction from HALTED.
- halt_req  in  1  pulse/level: stop execution at the next cycle boundary.
- cycle_limit  in  CNT_W  stop after this many executed cycles; 0 = unlimited.
- instr  in  32  current instruction word from core imem.
- core_rstn  out  1  active-low reset to core.
- core_en  out  1  execute enable to core (PC/regfile/dmem writes are gated by it).
- state  out  3  0 IDLE, 1 CRST, 2 RUN, 3 STEP, 4 HALTED.
- cycle_count  out  CNT_W  executed cycles since the last start.
- halt_cause  out  2  0 none, 1 host request, 2 ECALL/EBREAK, 3 cycle limit.
- done  out  1  one-cycle pulse on entry to HALTED.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, core_rstn=0, core_en=0, cycle_count=0, halt_cause=0, done=0.
  - A reset mid-run aborts immediately; no done pulse is generated.
- Outputs by state (Moore):
  - IDLE: core_rstn=0, core_en=0.
  - CRST: core_rstn=0, core_en=0.
  - RUN and STEP: core_rstn=1, core_en=1.
  - HALTED: core_rstn=1, core_en=0, so core state is preserved for inspection.
- IDLE -> CRST on start. In CRST, an internal counter loads RST_CYCLES-1 and counts down; CRST -> RUN when the counter reaches 0.
  - Net effect: core_rstn is low for exactly RST_CYCLES cycles.
  - Entering CRST clears cycle_count and halt_cause.
- cycle_count increments by 1 on every rising edge where core_en=1 and saturates at all-ones.
- Halt detection is evaluated in RUN and STEP on the current instr. Priority order:
  1. instr == 32'h00000073 (ECALL) or 32'h00100073 (EBREAK) -> cause 2. The instruction executes (core_en was 1 that cycle); next state is HALTED.
  2. cycle_limit != 0 and cycle_count+1 == cycle_limit -> cause 3. Next state is HALTED, with cycle_count == cycle_limit.
  3. halt_req=1 -> cause 1. That cycle still executes; next state is HALTED.
- STEP always returns to HALTED after one cycle. If no higher cause applies, halt_cause is kept at its previous value.
- HALTED transitions:
  - start -> CRST.
  - resume -> RUN. If cycle_count already equals a nonzero cycle_limit, resume is ignored.
  - step -> STEP.
  - Simultaneous inputs: start > resume > step.
  - halt_req in HALTED is ignored.
- Inputs while busy:
  - In CRST, RUN and STEP, start/resume/step are ignored.
  - In IDLE, only start is honoured.
- done: registered, high for exactly the first cycle state==HALTED after RUN or STEP. It does not fire on a reset.
- All outputs are registered. Latency from start pulse to first core_en=1 is RST_CYCLES+1 edges.

Test Plan:
- Fibonacci program, cycle_limit=376, start pulse:
  - core_rstn low 2 cycles, then core_en high 376 cycles.
  - HALTED, halt_cause=3, cycle_count=376, done pulses once, x10 holds 2971215073 and stays stable for 20 more cycles.
- Program ending in ECALL at PC 0x20, cycle_limit=0: halt after 9 executed cycles, halt_cause=2, cycle_count=9.
- halt_req asserted at cycle 50 of RUN:
  - HALTED with cycle_count=51, halt_cause=1.
  - Then 3 step pulses -> cycle_count=54, exactly 3 PC advances, done pulses 3 times.
  - Then resume -> RUN.
- ECALL reached on the same cycle cycle_count+1==cycle_limit: halt_cause=2 (ECALL priority).
- rstn dropped mid-RUN: all outputs return to reset values asynchronously, no done pulse. After rstn=1, the next start re-runs from cycle_count=0.
- In HALTED, start and resume asserted together: CRST entered, cycle_count cleared, core_rstn low for RST_CYCLES cycles.
